// File: rtl/sd_cmd_shift_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_shift_pkg
// Shared definitions for the SD command-line datapath: the command FSM state
// codes, SD frame lengths and the CRC7 generator polynomial.
// ---------------------------------------------------------------------------
package sd_cmd_shift_pkg;

    // State codes shared with sd_cmd_fsm
    typedef enum logic [2:0] {
        CMD_STATE_STOP         = 3'd0,
        CMD_STATE_WAIT_SEND    = 3'd1,
        CMD_STATE_SEND         = 3'd2,
        CMD_STATE_WAIT_RECEIVE = 3'd3,
        CMD_STATE_RECEIVE      = 3'd4
    } cmd_state_e;

    localparam int CMD_FRAME_BITS  = 48;   // start .. end bit of a command
    localparam int RESP_SHORT_BITS = 47;   // short response after the start bit
    localparam int RESP_LONG_BITS  = 136;  // R2 receive window
    localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

endpackage

// File: rtl/sd_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7
// Serial CRC7 (x^7+x^3+1), MSB first, initial value 0.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous clear to 0 (wins over enable)
//   enable  : shift bit_in into the CRC this cycle
//   bit_in  : serial data bit
//   crc     : current remainder
// ---------------------------------------------------------------------------
module sd_crc7
    import sd_cmd_shift_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[6];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'h00;
        end else if (clear) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_shift.sv
// ---------------------------------------------------------------------------
// sd_cmd_shift
// Bit-level datapath of the SD CMD line. Latches a command, serialises the
// 48-bit frame with its CRC7, captures 48-bit or 136-bit responses and checks
// their CRC and framing. Bit position comes from the command FSM counters.
//   in_sd_clk          : SD clock, rising edge
//   hrst_n             : asynchronous active-low reset
//   in_soft_reset      : synchronous active-low reset
//   in_command_ready   : load strobe (honoured in STOP only)
//   in_command_index   : command index
//   in_argument        : command argument
//   in_longresponse    : 1 = 136-bit R2 response expected
//   current_state      : command FSM state
//   has_send_bit       : FSM send counter 0..47
//   has_receive_bit    : FSM receive counter
//   in_sd_cmd          : synchronised CMD line
//   out_sd_cmd         : CMD drive value (1 when idle)
//   out_sd_cmd_oe      : CMD output enable
//   out_response       : captured response payload
//   out_resp_valid     : one-cycle completion pulse
//   out_resp_crc_err   : CRC7 mismatch on last response
//   out_resp_frame_err : bad transmission or end bit on last response
// ---------------------------------------------------------------------------
module sd_cmd_shift
    import sd_cmd_shift_pkg::*;
(
    input  logic         in_sd_clk,
    input  logic         hrst_n,
    input  logic         in_soft_reset,
    input  logic         in_command_ready,
    input  logic [5:0]   in_command_index,
    input  logic [31:0]  in_argument,
    input  logic         in_longresponse,
    input  logic [2:0]   current_state,
    input  logic [5:0]   has_send_bit,
    input  logic [7:0]   has_receive_bit,
    input  logic         in_sd_cmd,
    output logic         out_sd_cmd,
    output logic         out_sd_cmd_oe,
    output logic [127:0] out_response,
    output logic         out_resp_valid,
    output logic         out_resp_crc_err,
    output logic         out_resp_frame_err
);

    localparam logic [5:0] TX_CRC_FIRST  = 6'(CMD_FRAME_BITS - 8);   // 40
    localparam logic [5:0] TX_END_BIT    = 6'(CMD_FRAME_BITS - 1);   // 47
    localparam logic [7:0] RX_SHORT_LAST = 8'(RESP_SHORT_BITS - 1);  // 46
    localparam logic [7:0] RX_LONG_LAST  = 8'(RESP_LONG_BITS - 1);   // 135
    localparam logic [7:0] RX_LONG_END   = RX_LONG_LAST - 8'd1;      // 134

    cmd_state_e state;
    assign state = cmd_state_e'(current_state);

    logic [39:0]  cmd_frame;
    logic         long_resp;
    logic [126:0] rx_shift;
    logic [6:0]   rx_crc_seen;
    logic         rx_frame_bad;
    logic [6:0]   tx_crc;
    logic [6:0]   rx_crc;

    // ---------------- control decode ----------------
    logic       load;
    logic       tx_feed;
    logic [5:0] tx_idx;
    logic [2:0] tx_crc_idx;
    logic       rx_active;
    logic       rx_clear;
    logic       rx_payload_en;
    logic       rx_crc_en;
    logic       rx_crc_field;
    logic       rx_trans_pos;
    logic       rx_end_pos;
    logic       rx_done;

    assign load       = (state == CMD_STATE_STOP) && in_command_ready;
    assign tx_feed    = (state == CMD_STATE_SEND) && (has_send_bit < TX_CRC_FIRST);
    assign tx_idx     = TX_CRC_FIRST - 6'd1 - has_send_bit;
    assign tx_crc_idx = 3'(TX_END_BIT - 6'd1 - has_send_bit);

    // The start bit arrives in WAIT_RECEIVE and is 0, so clearing the RX CRC
    // there is equivalent to having fed it.
    assign rx_clear  = (state == CMD_STATE_WAIT_RECEIVE);
    assign rx_active = (state == CMD_STATE_RECEIVE);

    assign rx_payload_en = rx_active && (long_resp
        ? (has_receive_bit >= 8'd7 && has_receive_bit <= 8'd133)
        : (has_receive_bit >= 8'd1 && has_receive_bit <= 8'd38));
    assign rx_crc_en = rx_active && (long_resp
        ? (has_receive_bit >= 8'd7 && has_receive_bit <= 8'd126)
        : (has_receive_bit <= 8'd38));
    assign rx_crc_field = rx_active && (long_resp
        ? (has_receive_bit >= 8'd127 && has_receive_bit <= 8'd133)
        : (has_receive_bit >= 8'd39 && has_receive_bit <= 8'd45));
    assign rx_trans_pos = rx_active && (has_receive_bit == 8'd0);
    assign rx_end_pos   = rx_active &&
        (has_receive_bit == (long_resp ? RX_LONG_END : RX_SHORT_LAST));
    assign rx_done      = rx_active &&
        (has_receive_bit == (long_resp ? RX_LONG_LAST : RX_SHORT_LAST));

    // ---------------- CRC engines ----------------
    sd_crc7 u_tx_crc (
        .clk    (in_sd_clk),
        .rst_n  (hrst_n),
        .clear  (load || !in_soft_reset),
        .enable (tx_feed),
        .bit_in (cmd_frame[tx_idx]),
        .crc    (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clk    (in_sd_clk),
        .rst_n  (hrst_n),
        .clear  (rx_clear || !in_soft_reset),
        .enable (rx_crc_en),
        .bit_in (in_sd_cmd),
        .crc    (rx_crc)
    );

    // ---------------- send path (combinational) ----------------
    // NOTE: every output of this always_comb gets a default first, so no
    // path through the block can leave a latch behind.
    always_comb begin
        out_sd_cmd    = 1'b1;
        out_sd_cmd_oe = 1'b0;
        if (state == CMD_STATE_SEND) begin
            out_sd_cmd_oe = 1'b1;
            if (has_send_bit < TX_CRC_FIRST) begin
                out_sd_cmd = cmd_frame[tx_idx];
            end else if (has_send_bit < TX_END_BIT) begin
                out_sd_cmd = tx_crc[tx_crc_idx];
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge in_sd_clk or negedge hrst_n) begin
        if (!hrst_n) begin
            cmd_frame          <= '0;
            long_resp          <= 1'b0;
            rx_shift           <= '0;
            rx_crc_seen        <= '0;
            rx_frame_bad       <= 1'b0;
            out_response       <= '0;
            out_resp_valid     <= 1'b0;
            out_resp_crc_err   <= 1'b0;
            out_resp_frame_err <= 1'b0;
        end else if (!in_soft_reset) begin
            cmd_frame          <= '0;
            long_resp          <= 1'b0;
            rx_shift           <= '0;
            rx_crc_seen        <= '0;
            rx_frame_bad       <= 1'b0;
            out_response       <= '0;
            out_resp_valid     <= 1'b0;
            out_resp_crc_err   <= 1'b0;
            out_resp_frame_err <= 1'b0;
        end else begin
            out_resp_valid <= 1'b0;

            if (load) begin
                cmd_frame <= {2'b01, in_command_index, in_argument};
                long_resp <= in_longresponse;
            end

            if (rx_clear) begin
                rx_shift     <= '0;
                rx_crc_seen  <= '0;
                rx_frame_bad <= 1'b0;
            end else begin
                if (rx_payload_en) begin
                    rx_shift <= {rx_shift[125:0], in_sd_cmd};
                end
                if (rx_crc_field) begin
                    rx_crc_seen <= {rx_crc_seen[5:0], in_sd_cmd};
                end
                if ((rx_trans_pos && in_sd_cmd) || (rx_end_pos && !in_sd_cmd)) begin
                    rx_frame_bad <= 1'b1;
                end
            end

            // For short frames the end bit is sampled on the completion edge
            // itself, so it is folded in directly rather than via rx_frame_bad.
            if (rx_done) begin
                out_response       <= long_resp ? {rx_shift, 1'b0}
                                                : {90'b0, rx_shift[37:0]};
                out_resp_crc_err   <= (rx_crc_seen != rx_crc);
                out_resp_frame_err <= rx_frame_bad || (rx_end_pos && !in_sd_cmd);
                out_resp_valid     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sd_cmd_shift.md
# sd_cmd_shift

Bit-level datapath for the SD command line, next to `sd_cmd_fsm`. It latches a command (index and argument), serialises the 48-bit command frame with a serially computed CRC7 onto CMD, and captures 48-bit short or 136-bit long responses from CMD. It also checks the response CRC and framing. It holds no bit counters of its own: bit position is taken from the command FSM's `current_state`, `has_send_bit` and `has_receive_bit`.

## Interface
Parameters: none (frame lengths fixed by SD protocol).
- `in_sd_clk`  in  1  SD clock; all flops on rising edge
- `hrst_n`  in  1  asynchronous active-low reset
- `in_soft_reset`  in  1  synchronous active-low soft reset; same effect as `hrst_n`
- `in_command_ready`  in  1  load strobe; sampled only when `current_state`==STOP
- `in_command_index`  in  6  command index
- `in_argument`  in  32  command argument
- `in_longresponse`  in  1  1: 136-bit R2 response, 0: 48-bit
- `current_state`  in  3  command FSM state
- `has_send_bit`  in  6  FSM send counter, 0..47
- `has_receive_bit`  in  8  FSM receive counter, 0..46 / 0..135
- `in_sd_cmd`  in  1  CMD line input, already synchronised
- `out_sd_cmd`  out  1  CMD drive value, 1 when not sending
- `out_sd_cmd_oe`  out  1  CMD output enable
- `out_response`  out  128  captured response payload
- `out_resp_valid`  out  1  one-cycle pulse, response complete
- `out_resp_crc_err`  out  1  CRC7 mismatch on last response
- `out_resp_frame_err`  out  1  transmission bit ≠0 or end bit ≠1 on last response

## Operation
- State codes are shared: STOP=0, WAIT_SEND=1, SEND=2, WAIT_RECEIVE=3, RECEIVE=4.
- **Load:** `in_command_ready`=1 with `current_state`==STOP latches `cmd_frame[39:0]`={1'b0, 1'b1, index, argument} and latches `in_longresponse`. A strobe in any other state is ignored; the latched values are not disturbed.
- **Send:** applies while `current_state`==SEND. Let n=`has_send_bit`.
  - `out_sd_cmd_oe`=1.
  - n 0..39: `out_sd_cmd`=`cmd_frame[39-n]`; the CRC7 engine is fed the same bit.
  - n 40..46: `out_sd_cmd`=`crc[46-n]`, MSB first; CRC frozen.
  - n=47: `out_sd_cmd`=1 (end bit).
  - In all other states: `out_sd_cmd_oe`=0 and `out_sd_cmd`=1.
- **CRC7:** polynomial x^7+x^3+1, init 0, serial MSB-first.
  - Cleared on load.
  - Cleared when `current_state`==WAIT_RECEIVE; the start bit is 0, so the cleared value is correct.
- **Receive:** applies while `current_state`==RECEIVE. Let k=`has_receive_bit`; the sample at k is frame bit k+1 (the start bit was consumed in WAIT_RECEIVE).
  - Short frame:
    - k0: transmission bit, must be 0.
    - k1..38: shifted into payload.
    - CRC over k0..38; compared against k39..45.
    - k46: end bit, must be 1.
  - Long frame:
    - k0: transmission bit, must be 0.
    - k1..6: reserved, ignored.
    - k7..133: shifted into payload (CID/CSD[127:1]).
    - CRC over k7..126; compared against k127..133.
    - k134: end bit, must be 1.
    - k135: ignored.
- **Completion:** at k=46 (short) or k=135 (long), the following occur on the next edge:
  - the shift register is copied to `out_response`;
  - the error flags are updated;
  - `out_resp_valid` pulses for one cycle.
- **Payload layout:**
  - Short: `out_response[37:32]`=index, `[31:0]`=card status/argument, `[127:38]`=0.
  - Long: `[127:1]`=CID/CSD[127:1], `[0]`=0.
- **Hold and abort:** the outputs hold until the next completion. A response aborted by timeout (FSM goes WAIT_RECEIVE→STOP) leaves them unchanged and produces no pulse.

## Timing
- Reset values: `out_sd_cmd`=1, `out_sd_cmd_oe`=0, `out_response`=0, `out_resp_valid`=0, both error flags 0; internal frame, CRC and shift registers 0.
- Send path: combinational from registered `cmd_frame`, `crc`, `current_state` and `has_send_bit`; zero added latency, so bit n appears in the same cycle the FSM counter reads n.
- Receive path: samples `in_sd_cmd` on the rising edge in the cycle the counter reads k.
- `out_resp_valid` is registered: it asserts one cycle after the last RECEIVE cycle, coincident with the FSM being in STOP.
- Soft or hard reset mid-send or mid-receive: all registers return to reset values immediately (`hrst_n`) or at the next edge (`in_soft_reset`); no pulse is produced.

## Structure
- Shared package: the `CMD_STATE_*` codes, `CMD_FRAME_BITS`=48, `RESP_SHORT_BITS`=47, `RESP_LONG_BITS`=136, `CRC7_POLY`=7'h09.
- Sub-module `sd_crc7`.
  - Ports: clk, rst_n, clear, enable, bit_in; output crc[6:0].
  - Used twice: one instance for TX, one for RX.

## Test plan
- CMD0, arg 0x00000000 → serial stream 0x400000000095 MSB-first; `out_sd_cmd_oe` high for exactly 48 cycles.
- CMD8, arg 0x000001AA → stream 0x48000001AA87.
- R7 response bits 0x08000001AA13, short → `out_response`=0x08000001AA, `out_resp_valid` one pulse, crc_err=0, frame_err=0.
- Same response with end bit forced 0 → frame_err=1; with the last CRC bit flipped → crc_err=1.
- Long R2 with CID content carrying a valid CRC7 → `out_response[127:1]` equals the CID bits, crc_err=0; timeout path (STOP from WAIT_RECEIVE) → no pulse, previous response held.
- `in_command_ready` during SEND → frame unchanged; `in_soft_reset` low at n=20 → `out_sd_cmd`=1, `oe`=0 on the next cycle.
